// File: rtl/xdma_ring_ctrl.sv
// xdma_ring_ctrl: collects difftest packets into a ring of on-chip buffers and
// drains committed buffers as AXI-Stream frames toward the XDMA C2H channel.
//
// Ports:
//   clock, reset          sole clock; asynchronous active-high reset
//   difftest_data/_enable packet payload and its valid strobe
//   core_clock_enable     DUT clock gate, low while every buffer is committed
//   axi_t*                AXI-Stream master (tkeep constant all-ones)
//   occupancy             committed buffers not yet released
//   frame_seq             sequence number of the next frame to send
//
// Frame layout: each packet is {payload, hdr[15:0]} sent LSB first over BEATS
// beats; hdr = {frame_seq, count} on packet 0 of a frame, zero otherwise.
module xdma_ring_ctrl #(
    parameter int unsigned DATA_WIDTH      = 16000,
    parameter int unsigned AXIS_DATA_WIDTH = 512,
    parameter int unsigned NUM_BUFS        = 4,
    parameter int unsigned PKTS_PER_BUF    = 8,
    parameter int unsigned FLUSH_TIMEOUT   = 1024
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            difftest_data,
    input  logic                             difftest_enable,
    output logic                             core_clock_enable,
    output logic [AXIS_DATA_WIDTH-1:0]       axi_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]     axi_tkeep,
    output logic                             axi_tlast,
    output logic                             axi_tvalid,
    input  logic                             axi_tready,
    output logic [$clog2(NUM_BUFS+1)-1:0]    occupancy,
    output logic [7:0]                       frame_seq
);

    localparam int unsigned BEATS = (DATA_WIDTH + 16 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
    localparam int unsigned PKT_W = BEATS * AXIS_DATA_WIDTH;
    localparam int unsigned IW    = $clog2(NUM_BUFS);
    localparam int unsigned OW    = $clog2(NUM_BUFS + 1);
    localparam int unsigned SLOTS = NUM_BUFS * PKTS_PER_BUF;
    localparam int unsigned AW    = $clog2(SLOTS);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned TW    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Packet storage and per-buffer packet counts (contents need no reset)
    logic [DATA_WIDTH-1:0] mem_q     [SLOTS];
    logic [7:0]            cnt_mem_q [NUM_BUFS];

    // Write side state
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]    wr_cnt_q, wr_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Read side state
    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [7:0]       rd_cnt_q, rd_cnt_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [PKT_W-1:0] sh_q, sh_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic [7:0]       seq_q, seq_d;

    // Shared status
    logic [OW-1:0] occ_q, occ_d;
    logic          cce_q, cce_d;

    logic          sample_c;
    logic          full_c;
    logic          commit_full_c;
    logic          commit_flush_c;
    logic          commit_c;
    logic [7:0]    commit_cnt_c;
    logic [AW-1:0] wr_addr_c;
    logic [AW-1:0] rd_addr_c;
    logic [7:0]    rd_len_c;
    logic          last_pkt_c;
    logic [15:0]   hdr_c;
    logic          release_c;

    assign sample_c      = difftest_enable & cce_q;
    assign full_c        = (occ_q == OW'(NUM_BUFS));
    assign commit_full_c = sample_c && (wr_cnt_q == 8'(PKTS_PER_BUF - 1));
    // Timeout fires on the edge where the idle count would reach FLUSH_TIMEOUT;
    // the counter saturates so a flush blocked by a full ring retries later.
    assign commit_flush_c = (FLUSH_TIMEOUT != 0) && !sample_c && (wr_cnt_q != 8'd0) &&
                            !full_c && ((32'(tmo_q) + 32'd1) >= FLUSH_TIMEOUT);
    assign commit_c      = commit_full_c | commit_flush_c;
    assign commit_cnt_c  = commit_full_c ? 8'(PKTS_PER_BUF) : wr_cnt_q;
    assign wr_addr_c     = AW'(32'(wr_idx_q) * PKTS_PER_BUF + 32'(wr_cnt_q));
    assign rd_addr_c     = AW'(32'(rd_idx_q) * PKTS_PER_BUF + 32'(rd_cnt_q));
    assign rd_len_c      = cnt_mem_q[rd_idx_q];
    assign last_pkt_c    = (rd_cnt_q == rd_len_c - 8'd1);
    assign hdr_c         = (rd_cnt_q == 8'd0) ? {seq_q, rd_len_c} : 16'h0000;

    // Packet and count storage writes
    always_ff @(posedge clock) begin
        if (sample_c) begin
            mem_q[wr_addr_c] <= difftest_data;
        end
        if (commit_c) begin
            cnt_mem_q[wr_idx_q] <= commit_cnt_c;
        end
    end

    // Write pointer, slot counter and flush timer
    always_comb begin
        wr_idx_d = wr_idx_q;
        wr_cnt_d = wr_cnt_q;
        tmo_d    = tmo_q;
        if (commit_c) begin
            wr_cnt_d = 8'd0;
            wr_idx_d = wr_idx_q + IW'(1);
            tmo_d    = '0;
        end else if (sample_c) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
            tmo_d    = '0;
        end else if (wr_cnt_q == 8'd0) begin
            tmo_d = '0;
        end else if (32'(tmo_q) < FLUSH_TIMEOUT) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Read FSM next state; the beat shifter feeds axi_tdata straight from flops
    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_cnt_d  = rd_cnt_q;
        beat_d    = beat_q;
        sh_d      = sh_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        seq_d     = seq_q;
        release_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (occ_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_d     = PKT_W'({mem_q[rd_addr_c], hdr_c});
                beat_d   = '0;
                tvalid_d = 1'b1;
                tlast_d  = last_pkt_c && (BEATS == 1);
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                if (tvalid_q && axi_tready) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        if (last_pkt_c) begin
                            state_d = ST_RELEASE;
                        end else begin
                            rd_cnt_d = rd_cnt_q + 8'd1;
                            state_d  = ST_LOAD;
                        end
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        sh_d    = sh_q >> AXIS_DATA_WIDTH;
                        tlast_d = last_pkt_c && (beat_q == BW'(BEATS - 2));
                    end
                end
            end
            ST_RELEASE: begin
                release_c = 1'b1;
                rd_idx_d  = rd_idx_q + IW'(1);
                rd_cnt_d  = 8'd0;
                seq_d     = seq_q + 8'd1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Occupancy and the DUT clock gate derived from it
    always_comb begin
        occ_d = occ_q;
        case ({commit_c, release_c})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        cce_d = (occ_d != OW'(NUM_BUFS));
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_q <= '0;
            wr_cnt_q <= 8'd0;
            tmo_q    <= '0;
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            rd_cnt_q <= 8'd0;
            beat_q   <= '0;
            sh_q     <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            seq_q    <= 8'd0;
            occ_q    <= '0;
            cce_q    <= 1'b1;
        end else begin
            wr_idx_q <= wr_idx_d;
            wr_cnt_q <= wr_cnt_d;
            tmo_q    <= tmo_d;
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            rd_cnt_q <= rd_cnt_d;
            beat_q   <= beat_d;
            sh_q     <= sh_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            seq_q    <= seq_d;
            occ_q    <= occ_d;
            cce_q    <= cce_d;
        end
    end

    assign core_clock_enable = cce_q;
    assign axi_tdata         = sh_q[AXIS_DATA_WIDTH-1:0];
    assign axi_tkeep         = '1;
    assign axi_tlast         = tlast_q;
    assign axi_tvalid        = tvalid_q;
    assign occupancy         = occ_q;
    assign frame_seq         = seq_q;

endmodule

// File: doc/xdma_ring_ctrl.md
Name: xdma_ring_ctrl

Overview:
- Next-generation DiffTest-to-XDMA streaming controller.
- Collects per-cycle difftest batch packets into a ring of NUM_BUFS on-chip buffers, each holding up to PKTS_PER_BUF packets.
- Drains committed buffers as AXI-Stream frames toward the XDMA C2H channel, and back-pressures the DUT via core_clock_enable.
- Adds over the ping-pong generation: configurable buffer count and depth, timeout-based flush of partially filled buffers, a per-frame header carrying sequence number and packet count, and occupancy status.

Parameters:
- DATA_WIDTH, 16000, bits per difftest packet.
- AXIS_DATA_WIDTH, 512, AXI-Stream data width; multiple of 8.
- NUM_BUFS, 4, number of ring buffers; power of 2, ≥2.
- PKTS_PER_BUF, 8, packet slots per buffer; 1..255.
- FLUSH_TIMEOUT, 1024, idle cycles before a partial buffer is committed; 0 disables flush.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- difftest_data  in  DATA_WIDTH  packet payload.
- difftest_enable  in  1  payload valid this cycle.
- core_clock_enable  out  1  DUT clock gate; low = stall DUT.
- axi_tdata  out  AXIS_DATA_WIDTH  stream data.
- axi_tkeep  out  AXIS_DATA_WIDTH/8  byte enables; constant all-ones.
- axi_tlast  out  1  last beat of frame.
- axi_tvalid  out  1  beat valid.
- axi_tready  in  1  sink ready.
- occupancy  out  $clog2(NUM_BUFS+1)  committed, unreleased buffers.
- frame_seq  out  8  sequence number of the next frame to send.

Behaviour:
- Reset (async, immediate):
  - axi_tvalid=0, axi_tlast=0, occupancy=0, frame_seq=0, core_clock_enable=1.
  - Write/read pointers, slot counter and timeout counter cleared; FSM to IDLE.
  - Reset mid-frame abandons the frame; no partial data is sent afterwards.
- Sample condition: difftest_enable & core_clock_enable. A sample with core_clock_enable low is ignored.
- Write side:
  - Each sample writes slot wr_cnt of buffer wr_idx, then wr_cnt++.
  - When wr_cnt==PKTS_PER_BUF-1 at a sample, the buffer is committed with count=PKTS_PER_BUF; wr_cnt=0; wr_idx advances mod NUM_BUFS.
- Flush:
  - Timeout counter clears on every sample, increments while wr_cnt>0, and holds 0 while wr_cnt==0.
  - At FLUSH_TIMEOUT, the buffer is committed with count=wr_cnt, then wr_cnt=0 and wr_idx advances.
  - Flush is suppressed when occupancy==NUM_BUFS; it retries once a release frees a buffer.
  - A sample and a timeout in the same cycle: the sample wins; the timeout counter clears.
- occupancy: +1 on commit, −1 on release; simultaneous commit and release leaves it unchanged.
- core_clock_enable = (occupancy != NUM_BUFS), from registered state. A commit that fills the last buffer is still accepted; the DUT stalls from the next cycle.
- Frame format:
  - Each packet is serialised as {payload, hdr[15:0]}, LSB first, into BEATS = ceil((DATA_WIDTH+16)/AXIS_DATA_WIDTH) beats, with zero padding in the top beat.
  - hdr = {frame_seq, count} for packet 0 of a frame, 16'h0 for all other packets.
  - A frame is count*BEATS beats; axi_tlast is set only on the final beat.
- Read FSM:
  - IDLE: leave when occupancy>0; go to LOAD.
  - LOAD: one-cycle buffer read latency for slot rd_cnt of buffer rd_idx; go to STREAM.
  - STREAM: present beats; advance on tvalid&tready. After the last beat of a packet, return to LOAD for the next slot. After the final beat of the frame, go to RELEASE.
  - RELEASE: occupancy−1, rd_idx advances, frame_seq++ (wraps 255→0), back to IDLE.
- AXIS rules:
  - Once axi_tvalid rises, it and axi_tdata/axi_tlast hold until the handshake completes.
  - Between packets of one frame, axi_tvalid may drop for the LOAD cycle.
  - No combinational path from axi_tready to any output.
- Ordering: frames leave in commit order; packets within a frame in sample order.

Test Plan:
- PKTS_PER_BUF=8, AXIS=512, DATA_WIDTH=1000 (BEATS=2), 8 samples with tready=1 → one 16-beat frame, beat0[15:0]=16'h0008, tlast on beat 16 only, frame_seq 0→1, occupancy returns to 0.
- 3 samples then idle, FLUSH_TIMEOUT=16 → commit exactly 16 cycles after the last sample; 6-beat frame with hdr=16'h0003.
- tready=0 held, 32 continuous samples, NUM_BUFS=4 → occupancy=4, core_clock_enable low the cycle after the 32nd sample, samples 33+ ignored. Raise tready → four frames with seq 0..3, core_clock_enable high after the first RELEASE.
- Random tready toggling over 300 frames → no beat lost or duplicated, tdata stable while stalled, frame_seq wraps 255→0.
- Commit and RELEASE forced into the same cycle → occupancy unchanged.
- Assert reset mid-frame → outputs drop the same cycle (async); the next frame restarts at seq 0 with correct data.
